// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and types shared by fetch,
// stall queue and decode.
package fetch_pkg;

  localparam int INST_W = 16;
  localparam int PC_W = 16;
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;
  localparam logic [PC_W-1:0] DEF_RESET_PC = 16'h0000;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } fetch_state_e;

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
  } slot_t;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory read port.
// master = fetch side, slave = memory side.
interface fetch_unit_if;
  import fetch_pkg::*;

  logic              mem_ren;
  logic [PC_W-1:0]   mem_raddr;
  logic [INST_W-1:0] mem_rdata;

  modport master (
    output mem_ren,
    output mem_raddr,
    input  mem_rdata
  );

  modport slave (
    input  mem_ren,
    input  mem_raddr,
    output mem_rdata
  );

endinterface

// File: rtl/fetch_inflight_tracker.sv
// fetch_inflight_tracker: {valid, pc} delay line
// matching the memory latency; clr kills all slots.
module fetch_inflight_tracker
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr,
  input  slot_t slot_in,
  output slot_t slot_out
);

  slot_t stg [DEPTH];

  // shift every cycle; clear wipes the whole line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        stg[i] <= '0;
    end else begin
      stg[0] <= clr ? '0 : slot_in;
      for (int i = 1; i < DEPTH; i++)
        stg[i] <= clr ? '0 : stg[i-1];
    end
  end

  assign slot_out = stg[DEPTH-1];

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC, issue control, wrong-path
// squashing and registered instruction output.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              MEM_LATENCY = 2,
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  input  logic              hold,
  fetch_unit_if.master      mem,
  output logic [INST_W-1:0] cur_instruction,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid
);

  fetch_state_e    state_q;
  fetch_state_e    state_d;
  logic            issue;
  logic [PC_W-1:0] pc_q;
  slot_t           slot_in;
  slot_t           slot_out;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // one idle cycle after reset, then issue
  // whenever not held or redirected
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  issue = !hold && !flush;
      default: state_d = ST_IDLE;
    endcase
  end

  // program counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     pc_q <= RESET_PC;
    else if (flush) pc_q <= flush_pc;
    else if (issue) pc_q <= pc_q + 16'd1;
  end

  assign mem.mem_ren   = issue;
  assign mem.mem_raddr = pc_q;

  assign slot_in = '{valid: issue, pc: pc_q};

  fetch_inflight_tracker #(
    .DEPTH (MEM_LATENCY)
  ) u_trk (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (flush),
    .slot_in  (slot_in),
    .slot_out (slot_out)
  );

  // capture returning word when its slot survived
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_instruction <= NOP_INST;
      inst_pc         <= '0;
      inst_valid      <= 1'b0;
    end else if (!flush && slot_out.valid) begin
      cur_instruction <= mem.mem_rdata;
      inst_pc         <= slot_out.pc;
      inst_valid      <= 1'b1;
    end else begin
      cur_instruction <= NOP_INST;
      inst_pc         <= '0;
      inst_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: three DUTs (latency 2, 1, 4)
// share stimulus; outputs checked against a history model.
module tb_fetch_unit;

  localparam int NCYC = 1024;
  localparam int ND = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 2 : ((g == 1) ? 1 : 4);
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        hold = 1'b0;
  logic [15:0] flush_pc = 16'h0000;

  logic        ren_a   [ND];
  logic [15:0] raddr_a [ND];
  logic [15:0] cur_a   [ND];
  logic [15:0] ipc_a   [ND];
  logic        vld_a   [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int LAT = lat_of(g);
    fetch_unit_if mif ();
    logic [15:0] pipe [LAT];

    always @(posedge clk) begin
      pipe[0] <= mif.mem_ren ? (mif.mem_raddr + 16'h1000)
                             : 16'($urandom);
      for (int i = 1; i < LAT; i++)
        pipe[i] <= pipe[i-1];
    end

    assign mif.mem_rdata = pipe[LAT-1];

    fetch_unit #(
      .MEM_LATENCY (LAT),
      .RESET_PC    (16'h0000)
    ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .flush           (flush),
      .flush_pc        (flush_pc),
      .hold            (hold),
      .mem             (mif),
      .cur_instruction (cur_a[g]),
      .inst_pc         (ipc_a[g]),
      .inst_valid      (vld_a[g])
    );

    assign ren_a[g]   = mif.mem_ren;
    assign raddr_a[g] = mif.mem_raddr;
  end

  bit          iss  [NCYC];
  logic [15:0] ipc  [NCYC];
  bit          kill [NCYC];
  bit          rlow [NCYC];
  int          cyc = 0;
  bit          m_run = 1'b0;
  logic [15:0] m_pc = 16'h0000;
  int          checks = 0;
  int          fails = 0;

  task automatic chk(input string tag, input int g,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s lat=%0d cyc=%0d got %h want %h",
             tag, lat_of(g), cyc, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit f,
                      input logic [15:0] fp, input bit h);
    bit          e_ren;
    logic [15:0] e_addr;
    bit          ok;
    int          l;
    int          k;
    rst_n = r;
    flush = f;
    flush_pc = fp;
    hold = h;
    if (!r) begin
      e_ren = 1'b0;
      e_addr = 16'h0000;
    end else begin
      e_ren = m_run && !h && !f;
      e_addr = m_pc;
    end
    iss[cyc] = e_ren;
    ipc[cyc] = e_addr;
    kill[cyc] = !r || f;
    rlow[cyc] = !r;
    @(negedge clk);
    for (int g = 0; g < ND; g++) begin
      l = lat_of(g);
      k = cyc - l - 1;
      ok = !rlow[cyc] && (k >= 0);
      if (ok) ok = iss[k];
      for (int j = cyc - l; j < cyc; j++)
        if (j >= 0 && kill[j]) ok = 1'b0;
      chk("mem_ren", g, {15'd0, ren_a[g]}, {15'd0, e_ren});
      chk("mem_raddr", g, raddr_a[g], e_addr);
      chk("inst_valid", g, {15'd0, vld_a[g]}, {15'd0, ok});
      chk("inst_pc", g, ipc_a[g], ok ? ipc[k] : 16'h0000);
      chk("cur_inst", g, cur_a[g],
          ok ? (ipc[k] + 16'h1000) : 16'h0000);
    end
    if (!r) begin
      m_run = 1'b0;
      m_pc = 16'h0000;
    end else begin
      if (f)          m_pc = fp;
      else if (e_ren) m_pc = m_pc + 16'd1;
      m_run = 1'b1;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 16'h0, 0);
  endtask

  initial begin
    bit          r;
    bit          f;
    bit          h;
    logic [15:0] fp;
    #1;
    step(0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    run(12);
    step(1, 1, 16'h0040, 0);
    run(10);
    repeat (3) step(1, 0, 16'h0, 1);
    run(8);
    step(1, 1, 16'hFFFE, 0);
    run(10);
    repeat (2) step(1, 1, 16'h0020, 1);
    step(1, 0, 16'h0, 1);
    run(10);
    step(0, 0, 16'h0, 0);
    step(0, 0, 16'h0, 0);
    run(10);
    step(0, 0, 16'h0, 0);
    step(1, 1, 16'h0080, 0);
    run(10);
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) != 0);
      f = ($urandom_range(0, 9) == 0);
      h = ($urandom_range(0, 4) == 0);
      fp = ($urandom_range(0, 3) == 0)
           ? 16'($urandom_range(16'hFFFA, 16'hFFFF))
           : 16'($urandom);
      step(r, f, fp, h);
    end
    run(8);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
